piso_tx_ctrl: RTL and testbench

Frame controller that sequences a free-running parallel-in/serial-out shift register (MSB-first; shifts every cycle unless `LOAD` is high; serial input `SI` enters bit 0). It accepts parallel words on a valid/ready handshake, buffers one word, and issues `LOAD`/`PI` to the shift register with exact frame timing so words stream back-to-back with no gap. It also drives `SI` and provides frame qualifiers (`SO_VALID`, `SO_LAST`) for the downstream serial consumer.

---
 rtl/piso_tx_ctrl_if.sv | 16 +
 rtl/piso_tx_ctrl.sv | 57 +++++
 tb/tb_piso_tx_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_ctrl_if.sv
// piso_tx_ctrl_if: word handshake plus shift-register control/qualifier bundle.
interface piso_tx_ctrl_if #(
   parameter int WIDTH = 10
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             load;
   logic [WIDTH-1:0] pi;
   logic             si;
   logic             so_valid;
   logic             so_last;
   logic             busy;
   modport master (output in_data, in_valid, input in_ready, load, pi, si, so_valid, so_last, busy);
   modport slave (input in_data, in_valid, output in_ready, load, pi, si, so_valid, so_last, busy);
endinterface

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: frame sequencer for an external free-running MSB-first PISO shift register.
// Defining PISO_TX_CTRL_PARITY_EN appends a parity bit (fed through si) to every frame.
module piso_tx_ctrl #(
   parameter int WIDTH      = 10,
   parameter bit PARITY_ODD = 1'b0
) (
   input logic         clk,
   input logic         rst_n,
   piso_tx_ctrl_if.slave bus
);
`ifdef PISO_TX_CTRL_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(FRAME);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             hold_full;
   logic [WIDTH-1:0] hold_data;
   logic             last, load, accept;
   assign last   = state == SHIFT && cnt == CW'(FRAME - 1);
   assign load   = hold_full && (state == IDLE || last);
   assign accept = bus.in_valid && !hold_full;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         hold_full <= 1'b0;
         hold_data <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         hold_full <= accept || (hold_full && !load);
         if (accept) hold_data <= bus.in_data;
      end
   end
   always_comb begin
      state_nx = load ? SHIFT : (last ? IDLE : state);
      cnt_nx   = (load || last || state == IDLE) ? '0 : cnt + CW'(1);
   end
   always_comb begin
      bus.in_ready = !hold_full;
      bus.load     = load;
      bus.pi       = hold_data;
      bus.so_valid = state == SHIFT;
      bus.so_last  = last;
      bus.busy     = state == SHIFT || hold_full;
`ifdef PISO_TX_CTRL_PARITY_EN
      // hold_data still holds the just-loaded word during the cnt==0 cycle
      bus.si       = state == SHIFT && cnt == '0 && (^hold_data ^ PARITY_ODD);
`else
      bus.si       = 1'b0 & PARITY_ODD;
`endif
   end
endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: directed and random checks of piso_tx_ctrl driving a modelled shift register,
// at WIDTH 10, 2 and 32, against a bit-stream scoreboard built from accepted words.
`timescale 1ns/1ps
module tb_piso_tx_ctrl;
`ifdef PISO_TX_CTRL_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int F = PAR ? 11 : 10;
   logic        clk = 0, rst_n = 1;
   int          checks = 0, errors = 0, cyc = 0;
   logic [3:0]  iv = '0;
   logic [3:0]  rdy, ld, sv, sl, bz, si_a, o_a;
   logic [31:0] id [4] = '{default: 0};
   logic [31:0] pi_a [4];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic exp_bit(logic [31:0] w, int k, bit po);
      return k < 10 ? w[9 - k] : ^w[9:0] ^ po;
   endfunction
   for (genvar i = 0; i < 4; i++) begin : g
      localparam int W  = i == 1 ? 2 : i == 2 ? 32 : 10;
      localparam bit PO = i == 3;
      piso_tx_ctrl_if #(.WIDTH(W)) bus ();
      piso_tx_ctrl #(.WIDTH(W), .PARITY_ODD(PO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
      logic [W-1:0] sr;
      logic         v_r = 0;
      logic [31:0]  d_r = 0;
      logic [1:0]   q [$];
      logic [1:0]   e;
      bit           gap_chk = 0;
      int           nfr = 0, qn = 0;
      assign bus.in_valid = (i == 1 || i == 2) ? v_r : iv[i];
      assign bus.in_data  = (i == 1 || i == 2) ? d_r[W-1:0] : id[i][W-1:0];
      assign rdy[i]  = bus.in_ready;
      assign ld[i]   = bus.load;
      assign sv[i]   = bus.so_valid;
      assign sl[i]   = bus.so_last;
      assign bz[i]   = bus.busy;
      assign si_a[i] = bus.si;
      assign pi_a[i] = 32'(bus.pi);
      assign o_a[i]  = sr[W-1];
      // the controlled shift register: load wins, otherwise shift toward MSB with si into bit 0
      always_ff @(posedge clk) sr <= bus.load ? bus.pi : {sr[W-2:0], bus.si};
      // expected stream: each accepted word as MSB-first bits, plus parity, tagged with last flag
      always @(negedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q.delete();
            gap_chk = 0;
         end else begin
            if (gap_chk) check("gapless", bus.so_valid, 1);
            gap_chk = 0;
            if (bus.so_valid) begin
               check("bit_expected", q.size() != 0, 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  check("serial_bit", sr[W-1], e[1]);
                  check("so_last", bus.so_last, e[0]);
                  if (bus.so_last) nfr++;
                  gap_chk = bus.so_last && q.size() != 0;
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               for (int k = W - 1; k >= 0; k--) q.push_back({bus.in_data[k], !PAR && k == 0});
               if (PAR) q.push_back({^bus.in_data ^ PO, 1'b1});
            end
            qn = q.size();
         end
      end
      if (i == 1 || i == 2) begin : rnd
         initial begin
            wait (cyc >= 4);
            while (cyc < 1600) begin
               @(posedge clk);
               #1;
               v_r = $urandom_range(0, 3) != 0;
               d_r = $urandom;
            end
            v_r = 0;
         end
      end
   end
   task automatic send(int idx, logic [31:0] w);
      bit took = 0;
      iv[idx] = 1;
      id[idx] = w;
      for (int c = 0; c < 100 && !took; c++) begin
         @(negedge clk);
         took = rdy[idx];
         @(posedge clk);
         #1;
      end
      check("send_accept", took, 1);
   endtask
   task automatic frame_test(int idx, logic [31:0] w, bit po, output logic lb);
      send(idx, w);
      iv[idx] = 0;
      check("a1_load", ld[idx], 1);
      check("a1_in_ready", rdy[idx], 0);
      check("a1_so_valid", sv[idx], 0);
      check("a1_pi", pi_a[idx], w);
      @(posedge clk);
      #1;
      check("a2_load", ld[idx], 0);
      check("a2_in_ready", rdy[idx], 1);
      lb = 0;
      for (int k = 0; k < F; k++) begin
         check("frame_valid", sv[idx], 1);
         check("frame_bit", o_a[idx], exp_bit(w, k, po));
         check("frame_last", sl[idx], k == F - 1);
         lb = o_a[idx];
         @(posedge clk);
         #1;
      end
      check("post_valid", sv[idx], 0);
      check("post_busy", bz[idx], 0);
   endtask
   initial begin
      logic lb;
      int   n0, acc;
      bit   took, prev_ld;
      #2 rst_n = 0;
      #1;
      for (int j = 0; j < 4; j++) begin
         check("rst_load", ld[j], 0);
         check("rst_in_ready", rdy[j], 1);
         check("rst_so_valid", sv[j], 0);
         check("rst_so_last", sl[j], 0);
         check("rst_busy", bz[j], 0);
         check("rst_si", si_a[j], 0);
         check("rst_pi", pi_a[j], 0);
      end
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;
      frame_test(0, 32'h2A5, 0, lb);
      check("last_bit_2a5_even", lb, 1);
      frame_test(3, 32'h2A5, 1, lb);
      check("last_bit_2a5_odd", lb, PAR ? 0 : 1);
      frame_test(0, 32'h000, 0, lb);
      check("last_bit_000", lb, 0);
      fork
         begin
            send(0, 32'h3FF);
            send(0, 32'h001);
            iv[0] = 0;
         end
         begin
            took = 0;
            for (int c = 0; c < 20 && !took; c++) begin
               @(posedge clk);
               #1;
               took = sv[0];
            end
            check("b2b_start", took, 1);
            for (int k = 0; k < 2 * F; k++) begin
               check("b2b_valid", sv[0], 1);
               check("b2b_bit", o_a[0], exp_bit(k < F ? 32'h3FF : 32'h001, k % F, 0));
               if (k == F - 1) check("b2b_load_at_last", ld[0] & sl[0], 1);
               @(posedge clk);
               #1;
            end
            check("b2b_after", sv[0], 0);
         end
      join
      n0 = g[0].nfr;
      acc = 0;
      prev_ld = 0;
      iv[0] = 1;
      id[0] = $urandom & 32'h3FF;
      for (int c = 0; c < 2000 && acc < 50; c++) begin
         @(negedge clk);
         if (prev_ld) check("ready_after_load", rdy[0], 1);
         if (ld[0]) check("ready_during_load", rdy[0], 0);
         prev_ld = ld[0];
         took = rdy[0];
         @(posedge clk);
         #1;
         if (took) begin
            acc++;
            id[0] = $urandom & 32'h3FF;
         end
      end
      iv[0] = 0;
      check("bp_accepted", acc, 50);
      repeat (40) @(posedge clk);
      check("bp_frames", g[0].nfr - n0, 50);
      check("bp_drained", g[0].qn, 0);
      #1;
      send(0, 32'h3FF);
      send(0, 32'h2AA);
      iv[0] = 0;
      repeat (3) @(posedge clk);
      #2;
      check("mid_so_valid", sv[0], 1);
      check("mid_held", rdy[0], 0);
      rst_n = 0;
      #1;
      check("arst_load", ld[0], 0);
      check("arst_in_ready", rdy[0], 1);
      check("arst_so_valid", sv[0], 0);
      check("arst_so_last", sl[0], 0);
      check("arst_busy", bz[0], 0);
      check("arst_si", si_a[0], 0);
      check("arst_pi", pi_a[0], 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;
      frame_test(0, 32'h155, 0, lb);
      while (cyc < 1700) @(posedge clk);
      repeat (100) @(posedge clk);
      check("w2_drained", g[1].qn, 0);
      check("w32_drained", g[2].qn, 0);
      check("w2_frames", g[1].nfr > 20, 1);
      check("w32_frames", g[2].nfr > 20, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
